alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, 2-stage pipelined successor to the 4-bit combinational ALU.
//  - Generic operand WIDTH, carry/borrow result bit, zero flag, ready/valid handshakes on both sides.
//  - Accumulate mode: the previous result replaces operand A, so op chains run without a host round-trip.
//  - Sits between an operand sequencer (upstream) and a result sink (downstream).
// PARAMETERS
//  WIDTH   8   operand width in bits (>=2); result is WIDTH+1 bits
//  CNT_W   16  width of completed-operation counter
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          synchronous, active-high reset
//  in_valid   in   1          operand beat valid
//  in_ready   out  1          stage 1 can accept a beat
//  a          in   WIDTH      operand A
//  b          in   WIDTH      operand B
//  sel        in   3          opcode, see BEHAVIOUR
//  use_acc    in   1          1: operand A := previous result[WIDTH-1:0]; port a ignored
//  out_valid  out  1          result valid
//  out_ready  in   1          sink accepts result
//  y          out  WIDTH+1    result; bit WIDTH = carry/borrow, 0 for logic ops
//  zero       out  1          y[WIDTH-1:0] == 0
//  op_count   out  CNT_W      count of completed output transfers, wraps
// BEHAVIOUR
//  - Opcodes (y = WIDTH+1-bit result, arithmetic mod 2^(WIDTH+1)):
//    000 a+b | 001 a-b | 010 a+1 | 011 b-1 | 100 {0,a&b} | 101 {0,a|b} | 110 {0,a^b} | 111 {0,~b}
//  - Operands zero-extended to WIDTH+1 before add/sub.
//    a-b with a<b sets y[WIDTH]=1, e.g. W=8: 3-5 = 9'h1FE.
//  - Stage 1 (S1): registers a, b, sel, use_acc on in_valid && in_ready.
//  - Stage 2 (S2): computes from the S1 registers; registers y and zero.
//  - Advance rules:
//    s2_adv   = s1_valid && (!out_valid || out_ready)
//    in_ready = !s1_valid || s2_adv   (combinational; full throughput 1 op/cycle)
//  - Latency: beat accepted at edge k -> out_valid=1 after edge k+1 (2 cycles) if no backpressure.
//  - Backpressure: out_valid && !out_ready holds y, zero, out_valid stable.
//    S1 holds; in_ready drops when S1 is also full. No beat is ever dropped or duplicated.
//  - Accumulator acc_q (WIDTH bits):
//    - Loaded with y[WIDTH-1:0] whenever S2 captures a result.
//    - S2 uses acc_q as operand A when S1's use_acc=1, so it always holds the result of the
//      immediately preceding op in order, even back-to-back; no forwarding hazard exists.
//  - use_acc with ops 011/111 (A unused): no effect on the result.
//  - op_count increments on out_valid && out_ready; wraps from all-ones to 0.
//  - Simultaneous S2 drain and S1 refill in one cycle is legal and must sustain 1 op/cycle.
//  - Reset (rst=1 at an edge): s1_valid=0, out_valid=0, y=0, zero=0, acc_q=0, op_count=0.
//    in_ready=1 the cycle after reset. In-flight beats are discarded. rst has priority over every handshake.
// STRUCTURE
//  - Package alu_pkg: localparams OP_ADD..OP_NOT (3-bit opcodes); alu_op_t typedef of the opcode.
//  - Sub-module alu_core #(WIDTH): purely combinational (a, b, sel) -> y[WIDTH:0].
//    Instantiated once in S2.
//  - alu_pipe holds both pipeline registers, acc_q, op_count and the handshake logic.
// TESTING
//  1 W=8, out_ready=1: a=8'hFF,b=8'h01,sel=000 -> after 2 cycles y=9'h100, zero=1, op_count=1.
//  2 Stream 000..111 with a=8'hA5,b=8'h0F, one per cycle:
//    y = 0B4,096,0A6,00E,005,0AF,0AA,0F0 on consecutive cycles, in_ready never low.
//  3 Chain: (a=3,b=4,000), then use_acc=1 with (b=2,001), then use_acc=1 (010) back-to-back
//    -> y=007, 005, 006.
//  4 Hold out_ready=0 while offering 3 beats:
//    - in_ready drops after 2 accepted; y stays stable.
//    - Releasing out_ready delivers all beats in order, none lost.
//  5 Assert rst with both stages full: next cycle out_valid=0, in_ready=1, op_count=0.
//    Then use_acc op (b=1,000) -> y=001.
//  6 CNT_W=4: complete 17 ops -> op_count wraps to 1. Sub 8'h03-8'h05 -> y=9'h1FE, zero=0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode encodings and the opcode type shared by alu_pipe,
//                alu_core and the alu_pipe_if interface.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t OP_ADD = 3'b000;
    localparam alu_op_t OP_SUB = 3'b001;
    localparam alu_op_t OP_INC = 3'b010;
    localparam alu_op_t OP_DEC = 3'b011;
    localparam alu_op_t OP_AND = 3'b100;
    localparam alu_op_t OP_OR  = 3'b101;
    localparam alu_op_t OP_XOR = 3'b110;
    localparam alu_op_t OP_NOT = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_if
//  Description : Operand and result handshakes of alu_pipe. The master side is
//                the operand sequencer / result sink; the slave side is the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    alu_op_t            sel;
    logic               use_acc;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH:0]     y;
    logic               zero;
    logic [CNT_W-1:0]   op_count;

    modport master (
        output in_valid, a, b, sel, use_acc, out_ready,
        input  in_ready, out_valid, y, zero, op_count
    );

    modport slave (
        input  in_valid, a, b, sel, use_acc, out_ready,
        output in_ready, out_valid, y, zero, op_count
    );

endinterface
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Combinational WIDTH-bit ALU. Result is WIDTH+1 bits; the top
//                bit carries the carry/borrow and is 0 for logic operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          sel,
    output logic [WIDTH:0]   y
);

    localparam logic [WIDTH:0] c_one = (WIDTH+1)'(1);

    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;

    // Zero extension makes the top bit a true carry (add) or borrow (sub).
    assign w_a_ext = {1'b0, a};
    assign w_b_ext = {1'b0, b};

    always_comb begin
        y = '0;
        case (sel)
            OP_ADD:  y = w_a_ext + w_b_ext;
            OP_SUB:  y = w_a_ext - w_b_ext;
            OP_INC:  y = w_a_ext + c_one;
            OP_DEC:  y = w_b_ext - c_one;
            OP_AND:  y = {1'b0, a & b};
            OP_OR:   y = {1'b0, a | b};
            OP_XOR:  y = {1'b0, a ^ b};
            OP_NOT:  y = {1'b0, ~b};
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Two-stage pipelined ALU with ready/valid on both sides, an
//                accumulate mode and a completed-transfer counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    alu_pipe_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    // Stage 1 operand registers
    logic               r_s1_valid;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    alu_op_t            r_s1_sel;
    logic               r_s1_use_acc;

    // Stage 2 result registers
    logic               r_out_valid;
    logic [WIDTH:0]     r_y;
    logic               r_zero;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_op_count;

    logic               w_s2_adv;
    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [WIDTH-1:0]   w_op_a;
    logic [WIDTH:0]     w_y;

    assign w_s2_adv   = r_s1_valid && (!r_out_valid || bus.out_ready);
    assign w_in_ready = !r_s1_valid || w_s2_adv;
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

    // r_acc always holds the op immediately ahead of S1, so no forwarding.
    assign w_op_a = r_s1_use_acc ? r_acc : r_s1_a;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a   (w_op_a),
        .b   (r_s1_b),
        .sel (r_s1_sel),
        .y   (w_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_sel     <= OP_ADD;
            r_s1_use_acc <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid   <= 1'b1;
            r_s1_a       <= bus.a;
            r_s1_b       <= bus.b;
            r_s1_sel     <= bus.sel;
            r_s1_use_acc <= bus.use_acc;
        end else if (w_s2_adv) begin
            r_s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_zero      <= 1'b0;
            r_acc       <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= 1'b1;
            r_y         <= w_y;
            r_zero      <= (w_y[WIDTH-1:0] == '0);
            r_acc       <= w_y[WIDTH-1:0];
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_out_fire) begin
            r_op_count <= r_op_count + c_cnt_one;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.y         = r_y;
    assign bus.zero      = r_zero;
    assign bus.op_count  = r_op_count;

endmodule
`default_nettype wire
